// File: rtl/fp_addsub_pkg.sv
// Shared FP add/subtract definitions: sequencing states, alignment-width
// helper and the single/double precision field widths.
package fp_addsub_pkg;

  localparam int SP_EW = 8;
  localparam int SP_SW = 23;
  localparam int DP_EW = 11;
  localparam int DP_SW = 52;

  typedef enum logic [1:0] {
    IDLE,
    DIFF,
    SHIFT,
    DONE
  } align_state_e;

  // Width of the stored shift amount: holds 0..SW+4 (the clamp value).
  function automatic int shw_of(input int sw);
    return $clog2(sw + 5);
  endfunction

endpackage

// File: rtl/fp_align_stage_if.sv
// Start/done handshake and operand/result bus between the add/sub control
// FSM (master) and the alignment stage (slave).
interface fp_align_stage_if #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
);

  logic            start_i;
  logic [W-2:0]    DMP_i;
  logic [W-2:0]    DmP_i;
  logic            busy_o;
  logic            done_o;
  logic [EW-1:0]   exp_o;
  logic [SW:0]     mant_M_o;
  logic [SW+3:0]   mant_m_o;

  modport master (
    output start_i, DMP_i, DmP_i,
    input  busy_o, done_o, exp_o, mant_M_o, mant_m_o
  );

  modport slave (
    input  start_i, DMP_i, DmP_i,
    output busy_o, done_o, exp_o, mant_M_o, mant_m_o
  );

endinterface

// File: rtl/fp_align_shift_layer.sv
// One barrel-shifter layer: shifts right by 2^idx_i when enabled and reports
// whether any 1 bit fell off the LSB end.
module fp_align_shift_layer #(
  parameter int WIDTH = 27,
  parameter int IW    = 3
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic             en_i,
  input  logic [IW-1:0]    idx_i,
  output logic [WIDTH-1:0] shifted_o,
  output logic             dropped_o
);

  logic [31:0] amt;

  always_comb begin
    // NOTE: every output gets a value before any condition, so no latch can form.
    amt       = en_i ? (32'd1 << idx_i) : 32'd0;
    shifted_o = word_i >> amt;
    dropped_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (32'(i) < amt) begin
        dropped_o = dropped_o | word_i[i];
      end
    end
  end

endmodule

// File: rtl/fp_align_stage.sv
// Exponent difference and mantissa alignment of the smaller operand, one
// barrel layer per cycle. Define FP_ALIGN_STICKY_EN to accumulate sticky.
module fp_align_stage
  import fp_addsub_pkg::*;
#(
  parameter int W  = 32,
  parameter int EW = SP_EW,
  parameter int SW = SP_SW
) (
  input  logic              clk,
  input  logic              rst,
  fp_align_stage_if.slave   bus
);

  localparam int SHW = shw_of(SW);
  localparam int MW  = SW + 4;
  localparam int CW  = $clog2(SHW);
  localparam logic [EW:0] CLAMP = (EW + 1)'(MW);

  align_state_e   state_q;
  logic           busy_q;
  logic           done_q;
  logic [EW-1:0]  exp_q;
  logic [SW:0]    mant_M_q;
  logic [MW-1:0]  mant_m_q;
  logic [W-2:0]   dmp_q;
  logic [W-2:0]   dmnp_q;
  logic [SHW-1:0] d_q;
  logic [CW-1:0]  cnt_q;
  logic [MW-1:0]  word_q;
`ifdef FP_ALIGN_STICKY_EN
  logic           sticky_q;
  logic           sticky_d;
`endif

  logic           hid_M;
  logic           hid_m;
  logic [EW-1:0]  eff_M;
  logic [EW-1:0]  eff_m;
  logic [EW:0]    diff;
  logic [SHW-1:0] d_d;
  logic [MW-1:0]  layer_word;
  logic           layer_dropped;
  logic [MW-1:0]  mant_m_d;

  // Denormals carry no hidden bit and sit at effective exponent 1.
  assign hid_M = |dmp_q[W-2:SW];
  assign hid_m = |dmnp_q[W-2:SW];
  assign eff_M = hid_M ? dmp_q[W-2:SW]  : EW'(1);
  assign eff_m = hid_m ? dmnp_q[W-2:SW] : EW'(1);
  assign diff  = {1'b0, eff_M} - {1'b0, eff_m};
  assign d_d   = (diff > CLAMP) ? SHW'(MW) : diff[SHW-1:0];

  fp_align_shift_layer #(
    .WIDTH (MW),
    .IW    (CW)
  ) u_layer (
    .word_i    (word_q),
    .en_i      (d_q[cnt_q]),
    .idx_i     (cnt_q),
    .shifted_o (layer_word),
    .dropped_o (layer_dropped)
  );

`ifdef FP_ALIGN_STICKY_EN
  assign sticky_d = sticky_q | layer_dropped;
  assign mant_m_d = {layer_word[MW-1:1], layer_word[0] | sticky_d};
`else
  logic unused_dropped;
  assign unused_dropped = layer_dropped;
  assign mant_m_d       = layer_word;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register sees
    // the pre-edge values of the others, whatever the statement order.
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      exp_q    <= '0;
      mant_M_q <= '0;
      mant_m_q <= '0;
      dmp_q    <= '0;
      dmnp_q   <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      word_q   <= '0;
`ifdef FP_ALIGN_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            dmp_q   <= bus.DMP_i;
            dmnp_q  <= bus.DmP_i;
            busy_q  <= 1'b1;
            state_q <= DIFF;
          end
        end
        DIFF: begin
          d_q     <= d_d;
          word_q  <= {hid_m, dmnp_q[SW-1:0], 3'b000};
          cnt_q   <= '0;
`ifdef FP_ALIGN_STICKY_EN
          sticky_q <= 1'b0;
`endif
          state_q <= SHIFT;
        end
        SHIFT: begin
          word_q <= layer_word;
`ifdef FP_ALIGN_STICKY_EN
          sticky_q <= sticky_d;
`endif
          cnt_q  <= cnt_q + CW'(1);
          // Last layer: results go straight to the output registers.
          if (cnt_q == CW'(SHW - 1)) begin
            exp_q    <= eff_M;
            mant_M_q <= {hid_M, dmp_q[SW-1:0]};
            mant_m_q <= mant_m_d;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.exp_o    = exp_q;
  assign bus.mant_M_o = mant_M_q;
  assign bus.mant_m_o = mant_m_q;

endmodule

// File: doc/fp_align_stage.md
# fp_align_stage

Exponent-difference and mantissa-alignment stage of the FP add/subtract datapath, directly downstream of the operand classification stage that produces the ordered magnitudes (larger DMP, smaller DmP). It takes the two W-1-bit magnitude words and restores hidden bits, handling denormals. It then right-shifts the smaller significand by the exponent difference, one barrel layer per cycle, and returns the common exponent plus both aligned significands, with guard, round and sticky bits, to the adder stage. Operation is start/done handshaked, driven by the add/sub control FSM.

## Interface
- W, 32, total IEEE-754 word width (32 or 64)
- EW, 8, exponent width (11 when W=64)
- SW, 23, stored fraction width (52 when W=64); W = EW+SW+1 required
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high; one clock domain (clk)
- start_i  in  1  request; sampled only in IDLE
- DMP_i  in  W-1  larger magnitude {exp, frac}; must not change while busy_o=1
- DmP_i  in  W-1  smaller magnitude {exp, frac}
- busy_o  out  1  high in DIFF, SHIFT, DONE
- done_o  out  1  one-cycle pulse, results valid
- exp_o  out  EW  exponent of DMP (effective exponent 1 if field is 0)
- mant_M_o  out  SW+1  {hidden, frac} of DMP
- mant_m_o  out  SW+4  aligned {hidden, frac, G, R, S} of DmP

## Operation
- Hidden bit = 1 if the exponent field ≠ 0. Otherwise hidden = 0 and the effective exponent = 1 (denormal).
- DIFF: latch operands. Compute d = eff_exp(DMP) − eff_exp(DmP), which is always ≥ 0 given the input ordering.
- Clamp d to SW+4 and store it in SHW = clog2(SW+5) bits. Pre-align the small word as {hidden, frac, 3'b000}. Clear sticky_r.
- SHIFT: counter k = 0..SHW-1. If d[k] = 1, shift the word right by 2^k. sticky_r |= OR of the dropped bits.
- DONE: load outputs. mant_m_o = {word[SW+3:1], word[0] | sticky_r}. Pulse done_o. Return to IDLE next cycle.
- States: IDLE →(start_i) DIFF → SHIFT (SHW cycles) → DONE → IDLE.
- start_i outside IDLE is ignored and not queued.
- Clamp at SW+4 shifts out every bit. The result is then 0 except the sticky bit.
- Output registers change only on entering DONE. They hold between operations.

## Timing
- Reset: state IDLE; busy_o, done_o, exp_o, mant_M_o, mant_m_o, counter and sticky_r all 0.
- start_i high at edge n: DIFF is in cycle n+1, SHIFT in n+2..n+SHW+1, and done_o = 1 in cycle n+SHW+2.
- Latency is fixed: 7 cycles for W=32 (SHW=5), 8 cycles for W=64 (SHW=6).
- Back-to-back throughput is one operation per SHW+3 cycles. start_i can be accepted in the cycle after DONE.
- rst during any state: next cycle is IDLE, all outputs 0, no done_o pulse. The operation is lost.
- rst and start_i together: rst wins.

## Configuration
- FP_ALIGN_STICKY_EN defined: sticky accumulation as described.
- FP_ALIGN_STICKY_EN undefined: sticky_r logic is removed and bits shifted below the LSB are discarded. mant_m_o[0] is the plain shifted bit.
- Latency is identical in both builds.

## Structure
- Shared package fp_addsub_pkg holds:
  - the state enum (IDLE, DIFF, SHIFT, DONE);
  - the helper function computing SHW;
  - the constants SP_EW=8, SP_SW=23, DP_EW=11, DP_SW=52.
- One sub-module, fp_align_shift_layer: a single barrel layer. Inputs: word, layer enable, layer index. Outputs: shifted word and the OR of dropped bits.
- The FSM, counter and output registers live in fp_align_stage.

## Test plan
- W=32, DMP=0x40400000, DmP=0x3F800000, start_i at edge 0.
  - Expect done_o in cycle 7, exp_o=0x80, mant_M_o=0xC00000, mant_m_o=0x2000000.
- DMP=0x3F800001, DmP=0x3F800000 (d=0) → mant_m_o=0x4000000, mant_M_o=0x800001.
- DMP=0x41800000, DmP=0x3F800001 (d=4) → mant_m_o=0x0400001 with the macro defined, 0x0400000 without.
- DMP=0x7F000000, DmP=0x00800001 (d=253, clamped to 27) → mant_m_o=0x0000001 with the macro defined, 0 without.
- Denormal case: DMP=0x00800000, DmP=0x00000003 → exp_o=1, d=0, mant_m_o=0x0000018, mant_M_o=0x800000.
- Control corner cases:
  - start_i pulsed again in cycle 3 → ignored; exactly one done_o.
  - rst in cycle 4 → no done_o, all outputs 0, busy_o=0 from cycle 5.
  - A new start_i after reset completes with normal latency.
